ocx_tlx_framer_cmd_sched: RTL
=============================

Name: ocx_tlx_framer_cmd_sched

Overview:
Credit-aware scheduler sitting between two framer-side queues and the TLX flit framer. The two queues are the command FIFO (VC3) and the response FIFO (VC0), each an instance of the framer cmd FIFO. Each cycle it picks an eligible queue by round-robin, pops the entry into a registered output stage (pulsing that queue's rd_done), and consumes one TL credit. It presents the entry to the framer with a valid/ready handshake and tracks credits returned by the link partner.

Parameters:
DATA_WIDTH, 172, entry width (matches FIFO data_out)
CREDIT_WIDTH, 8, width of each credit counter; max credits = 2^CREDIT_WIDTH-1
RET_WIDTH, 4, width of per-cycle credit return count

Ports:
clock  in  1  single clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
cmd_data_in  in  DATA_WIDTH  head entry of command FIFO
cmd_data_available  in  1  command FIFO non-empty
cmd_rd_done  out  1  pop pulse to command FIFO
rsp_data_in  in  DATA_WIDTH  head entry of response FIFO
rsp_data_available  in  1  response FIFO non-empty
rsp_rd_done  out  1  pop pulse to response FIFO
credit_init  in  1  pulse: load initial credits
init_cmd_credits  in  CREDIT_WIDTH  initial VC3 credits
init_rsp_credits  in  CREDIT_WIDTH  initial VC0 credits
cmd_credit_ret  in  RET_WIDTH  VC3 credits returned this cycle
rsp_credit_ret  in  RET_WIDTH  VC0 credits returned this cycle
flit_valid  out  1  output stage holds an entry
flit_data  out  DATA_WIDTH  output entry
flit_is_rsp  out  1  1 = entry came from the response FIFO
flit_ready  in  1  framer accepts the entry this cycle
cmd_credits  out  CREDIT_WIDTH  current VC3 credit count
rsp_credits  out  CREDIT_WIDTH  current VC0 credit count
credit_overflow_error  out  1  pulse: return would exceed max, clamped

Behaviour:
- Reset (async, active-high): state=INIT; flit_valid=0, flit_data=0, flit_is_rsp=0; both credit counters=0; last_grant=rsp, so cmd wins the first tie; rd_done outputs=0; error=0.
- States:
  - INIT: no grants; exits to RUN on credit_init.
  - RUN: normal scheduling.
  - credit_init in RUN: reloads both counters; no grant that cycle; stays in RUN.
- Eligibility in RUN:
  - cmd_elig = cmd_data_available && cmd_credits != 0.
  - rsp_elig likewise, using rsp_data_available and rsp_credits.
- out_free = !flit_valid || flit_ready.
- Grant occurs when out_free and at least one source is eligible.
  - Exactly one eligible: that source wins.
  - Both eligible: the source opposite last_grant wins.
  - last_grant updates only on a grant.
- Grant cycle actions, all combinational outputs in the same cycle:
  - Assert the winner's rd_done for exactly one cycle.
  - Capture the winner's data into flit_data at the clock edge; set flit_is_rsp; set flit_valid=1 at the next edge.
  - Latency: FIFO head to flit_valid is 1 cycle.
- Accept with no new grant (flit_valid && flit_ready): flit_valid=0 next cycle; flit_data holds its value.
- flit_valid && !flit_ready: output stage holds; no grant; rd_done=0.
- Back-to-back: with flit_ready held high, the block sustains one grant per cycle.
- Credit arithmetic, per VC per cycle: next = cur + ret - consumed.
  - Computed at CREDIT_WIDTH+1 bits; consumed is 0 or 1.
  - If the result exceeds 2^CREDIT_WIDTH-1, clamp to max and pulse credit_overflow_error for 1 cycle.
  - credit_init overrides the arithmetic: counter = init value; returns that cycle are dropped.
- Credits at 0 with a return of N arriving the same cycle: that source is not eligible this cycle; it is eligible next cycle.
- rd_done is never asserted while the corresponding data_available=0. The grant logic guarantees this, so the FIFO underflow condition cannot occur.
- Reset mid-operation: all state is lost immediately. A held flit is discarded; the upstream FIFOs are reset by the same reset.

Decomposition:
- Shared package ocx_tlx_framer_pkg holds:
  - state encoding (ST_INIT, ST_RUN);
  - source encoding (SRC_CMD=0, SRC_RSP=1);
  - DATA_WIDTH default 172.
- One sub-module, ocx_tlx_credit_cntr, instantiated twice (VC3, VC0).
  - Handles load, add return, subtract consume, clamp and overflow pulse.
  - The arbiter and output stage stay in the top module.

Test Plan:
- Reset, then cmd_data_available=1 with no credit_init -> no rd_done, flit_valid=0, credits=0.
- credit_init with cmd=2, rsp=2; both FIFOs available; flit_ready=1 -> grants cmd,rsp,cmd,rsp on consecutive cycles; then both credits=0 and grants stop; flit_is_rsp sequence 0,1,0,1.
- init cmd=3; flit_ready=0 after the first grant -> flit_valid held, cmd_rd_done single pulse, cmd_credits=2; 4 cycles later flit_ready=1 -> next grant in the same cycle and flit_valid stays 1.
- cmd_credits=0, cmd_credit_ret=1 and available=1 in cycle T -> no grant at T; grant at T+1; cmd_credits 1 then 0.
- CREDIT_WIDTH=8, cmd_credits=250, cmd_credit_ret=10 -> cmd_credits=255, credit_overflow_error pulse 1 cycle.
- Grant in progress with reset asserted asynchronously mid-cycle -> flit_valid, rd_done and credits go to 0 immediately; after deassert the state is INIT.

Source files
------------

// File: rtl/ocx_tlx_framer_pkg.sv
// ----------------------------------------------------------------------------
// ocx_tlx_framer_pkg
// Shared definitions for the TLX framer command scheduler:
//   - scheduler state encoding (ST_INIT, ST_RUN)
//   - source encoding (SRC_CMD = command FIFO / VC3, SRC_RSP = response FIFO / VC0)
//   - default entry width
//   - rr_pick: round-robin winner between the two sources
// ----------------------------------------------------------------------------
package ocx_tlx_framer_pkg;

  localparam int DATA_WIDTH_DEF = 172;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    SRC_CMD = 1'b0,
    SRC_RSP = 1'b1
  } src_e;

  // Winner when at least one source is eligible. A tie goes to the source
  // that did not win last time.
  function automatic src_e rr_pick(input logic cmd_elig, input logic rsp_elig,
                                   input src_e last_grant);
    src_e win;
    if (cmd_elig && rsp_elig) begin
      win = (last_grant == SRC_CMD) ? SRC_RSP : SRC_CMD;
    end else if (rsp_elig) begin
      win = SRC_RSP;
    end else begin
      win = SRC_CMD;
    end
    return win;
  endfunction

endpackage

// File: rtl/ocx_tlx_framer_cmd_sched_if.sv
// ----------------------------------------------------------------------------
// ocx_tlx_framer_cmd_sched_if
// Bundles every non-clock/reset signal of the scheduler.
//   master : scheduler side (consumes FIFO heads, credits, flit_ready;
//            drives rd_done pulses, flit output stage, credit counts, error)
//   slave  : environment side (FIFOs, credit source, framer)
// ----------------------------------------------------------------------------
interface ocx_tlx_framer_cmd_sched_if
  import ocx_tlx_framer_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CREDIT_WIDTH = 8,
  parameter int RET_WIDTH    = 4
);

  // Command FIFO (VC3)
  logic [DATA_WIDTH-1:0]   cmd_data_in;
  logic                    cmd_data_available;
  logic                    cmd_rd_done;
  // Response FIFO (VC0)
  logic [DATA_WIDTH-1:0]   rsp_data_in;
  logic                    rsp_data_available;
  logic                    rsp_rd_done;
  // Credit management
  logic                    credit_init;
  logic [CREDIT_WIDTH-1:0] init_cmd_credits;
  logic [CREDIT_WIDTH-1:0] init_rsp_credits;
  logic [RET_WIDTH-1:0]    cmd_credit_ret;
  logic [RET_WIDTH-1:0]    rsp_credit_ret;
  logic [CREDIT_WIDTH-1:0] cmd_credits;
  logic [CREDIT_WIDTH-1:0] rsp_credits;
  logic                    credit_overflow_error;
  // Framer output stage
  logic                    flit_valid;
  logic [DATA_WIDTH-1:0]   flit_data;
  logic                    flit_is_rsp;
  logic                    flit_ready;

  modport master (
    input  cmd_data_in, cmd_data_available, rsp_data_in, rsp_data_available,
    input  credit_init, init_cmd_credits, init_rsp_credits,
    input  cmd_credit_ret, rsp_credit_ret, flit_ready,
    output cmd_rd_done, rsp_rd_done, flit_valid, flit_data, flit_is_rsp,
    output cmd_credits, rsp_credits, credit_overflow_error
  );

  modport slave (
    output cmd_data_in, cmd_data_available, rsp_data_in, rsp_data_available,
    output credit_init, init_cmd_credits, init_rsp_credits,
    output cmd_credit_ret, rsp_credit_ret, flit_ready,
    input  cmd_rd_done, rsp_rd_done, flit_valid, flit_data, flit_is_rsp,
    input  cmd_credits, rsp_credits, credit_overflow_error
  );

endinterface

// File: rtl/ocx_tlx_credit_cntr.sv
// ----------------------------------------------------------------------------
// ocx_tlx_credit_cntr
// One TL virtual-channel credit counter.
//   clock, reset : rising-edge clock, async active-high reset (count -> 0)
//   load         : load load_val, dropping any return this cycle
//   load_val     : initial credit count
//   ret          : credits returned by the link partner this cycle
//   consume      : one credit spent this cycle
//   credits      : current count
//   overflow     : one-cycle pulse, registered alongside the clamped count
// ----------------------------------------------------------------------------
module ocx_tlx_credit_cntr #(
  parameter int CREDIT_WIDTH = 8,
  parameter int RET_WIDTH    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [CREDIT_WIDTH-1:0] load_val,
  input  logic [RET_WIDTH-1:0]    ret,
  input  logic                    consume,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    overflow
);

  localparam logic [CREDIT_WIDTH:0] MAX_CREDITS = {1'b0, {CREDIT_WIDTH{1'b1}}};

  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic                    overflow_q, overflow_d;
  logic [CREDIT_WIDTH:0]   sum;

  // Arithmetic is one bit wider than the counter so an overshoot is visible.
  // consume is only asserted when the count is non-zero, so the subtraction
  // never wraps.
  always_comb begin
    sum = {1'b0, credits_q}
        + {{(CREDIT_WIDTH + 1 - RET_WIDTH){1'b0}}, ret}
        - {{CREDIT_WIDTH{1'b0}}, consume};
    credits_d  = credits_q;
    overflow_d = 1'b0;
    if (load) begin
      credits_d = load_val;
    end else if (sum > MAX_CREDITS) begin
      credits_d  = MAX_CREDITS[CREDIT_WIDTH-1:0];
      overflow_d = 1'b1;
    end else begin
      credits_d = sum[CREDIT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credits_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

  assign credits  = credits_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/ocx_tlx_framer_cmd_sched.sv
// ----------------------------------------------------------------------------
// ocx_tlx_framer_cmd_sched
// Credit-aware round-robin scheduler between the command FIFO (VC3) and the
// response FIFO (VC0), feeding a one-entry registered output stage toward the
// TLX flit framer.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (master) : FIFO heads/available, rd_done pops, credit init/returns,
//                  flit valid/ready/data/is_rsp, credit counts, overflow error
// A grant pops the winner combinationally (rd_done) and registers its entry
// into the output stage on the same edge, so FIFO head to flit_valid is one
// cycle and one grant per cycle is sustained while flit_ready stays high.
// ----------------------------------------------------------------------------
module ocx_tlx_framer_cmd_sched
  import ocx_tlx_framer_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CREDIT_WIDTH = 8,
  parameter int RET_WIDTH    = 4
) (
  input logic                         clock,
  input logic                         reset,
  ocx_tlx_framer_cmd_sched_if.master  bus
);

  state_e                  state_q, state_d;
  src_e                    last_grant_q, last_grant_d;
  logic                    flit_valid_q, flit_valid_d;
  logic [DATA_WIDTH-1:0]   flit_data_q, flit_data_d;
  logic                    flit_is_rsp_q, flit_is_rsp_d;

  logic [CREDIT_WIDTH-1:0] cmd_credits_w, rsp_credits_w;
  logic                    cmd_ovf_w, rsp_ovf_w;
  logic                    out_free, cmd_elig, rsp_elig;
  logic                    grant;
  src_e                    win;
  logic                    cmd_pop, rsp_pop;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    flit_valid_d  = flit_valid_q;
    flit_data_d   = flit_data_q;
    flit_is_rsp_d = flit_is_rsp_q;
    grant         = 1'b0;
    win           = SRC_CMD;

    out_free = !flit_valid_q || bus.flit_ready;
    // Eligibility uses the registered count: a return arriving while the
    // count is zero only makes the source eligible on the following cycle.
    cmd_elig = bus.cmd_data_available && (cmd_credits_w != '0);
    rsp_elig = bus.rsp_data_available && (rsp_credits_w != '0);

    case (state_q)
      ST_INIT: begin
        if (bus.credit_init) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A credit reload cycle never grants, so the consume cannot race the load.
        if (!bus.credit_init && out_free && (cmd_elig || rsp_elig)) begin
          grant = 1'b1;
          win   = rr_pick(cmd_elig, rsp_elig, last_grant_q);
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (grant) begin
      last_grant_d  = win;
      flit_valid_d  = 1'b1;
      flit_is_rsp_d = (win == SRC_RSP);
      flit_data_d   = (win == SRC_RSP) ? bus.rsp_data_in : bus.cmd_data_in;
    end else if (bus.flit_ready) begin
      flit_valid_d = 1'b0;
    end

    cmd_pop = grant && (win == SRC_CMD);
    rsp_pop = grant && (win == SRC_RSP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      last_grant_q  <= SRC_RSP;
      flit_valid_q  <= 1'b0;
      flit_data_q   <= '0;
      flit_is_rsp_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      flit_valid_q  <= flit_valid_d;
      flit_data_q   <= flit_data_d;
      flit_is_rsp_q <= flit_is_rsp_d;
    end
  end

  ocx_tlx_credit_cntr #(
    .CREDIT_WIDTH (CREDIT_WIDTH),
    .RET_WIDTH    (RET_WIDTH)
  ) u_vc3_cntr (
    .clock    (clock),
    .reset    (reset),
    .load     (bus.credit_init),
    .load_val (bus.init_cmd_credits),
    .ret      (bus.cmd_credit_ret),
    .consume  (cmd_pop),
    .credits  (cmd_credits_w),
    .overflow (cmd_ovf_w)
  );

  ocx_tlx_credit_cntr #(
    .CREDIT_WIDTH (CREDIT_WIDTH),
    .RET_WIDTH    (RET_WIDTH)
  ) u_vc0_cntr (
    .clock    (clock),
    .reset    (reset),
    .load     (bus.credit_init),
    .load_val (bus.init_rsp_credits),
    .ret      (bus.rsp_credit_ret),
    .consume  (rsp_pop),
    .credits  (rsp_credits_w),
    .overflow (rsp_ovf_w)
  );

  assign bus.cmd_rd_done           = cmd_pop;
  assign bus.rsp_rd_done           = rsp_pop;
  assign bus.flit_valid            = flit_valid_q;
  assign bus.flit_data             = flit_data_q;
  assign bus.flit_is_rsp           = flit_is_rsp_q;
  assign bus.cmd_credits           = cmd_credits_w;
  assign bus.rsp_credits           = rsp_credits_w;
  assign bus.credit_overflow_error = cmd_ovf_w | rsp_ovf_w;

endmodule
